// File: rtl/pwm_chan_seq.sv
// pwm_chan_seq: per-channel PWM time-base sequencer (period counter, shadow loads, one-shot, waveform).
// Optional macro PWM_OS_REPEAT_EN: when defined, one-shot runs cfg_os_rpt+1 periods; otherwise exactly one.
`default_nettype none

module pwm_chan_seq #(
    parameter int CNT_W = 16,
    parameter int OS_W  = 8
) (
    input  logic             mclk,
    input  logic             h_reset,
    input  logic             cfg_pwm_enb,
    input  logic             cfg_pwm_run,
    input  logic             cfg_pwm_dupdate,
    input  logic             cfg_oneshot,
    input  logic             cfg_polarity,
    input  logic [OS_W-1:0]  cfg_os_rpt,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_compare,
    input  logic             cfg_ld_req,
    output logic             pwm_out,
    output logic             pwm_ovflow,
    output logic             pwm_os_done,
    output logic             ld_pend,
    output logic [CNT_W-1:0] cnt_val,
    output logic             busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_STOP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] act_compare_q, act_compare_d;
    logic             ld_pend_q, ld_pend_d;
    logic             ovflow_q, ovflow_d;
    logic             os_done_q, os_done_d;
    logic             out_q, out_d;

    logic w_counting;
    logic w_period_end;
    logic w_os_last;
    logic w_os_finish;

`ifdef PWM_OS_REPEAT_EN
    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    assign w_os_last = (os_cnt_q == cfg_os_rpt);
`else
    logic os_rpt_unused;
    assign os_rpt_unused = ^cfg_os_rpt;
    assign w_os_last     = 1'b1;
`endif

    assign w_counting   = (state_q == S_RUN) || (state_q == S_STOP);
    assign w_period_end = w_counting && (cnt_q == act_period_q);
    assign w_os_finish  = w_period_end && cfg_oneshot && w_os_last;

    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            act_period_q  <= '0;
            act_compare_q <= '0;
            ld_pend_q     <= 1'b0;
            ovflow_q      <= 1'b0;
            os_done_q     <= 1'b0;
            out_q         <= 1'b0;
`ifdef PWM_OS_REPEAT_EN
            os_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            act_period_q  <= act_period_d;
            act_compare_q <= act_compare_d;
            ld_pend_q     <= ld_pend_d;
            ovflow_q      <= ovflow_d;
            os_done_q     <= os_done_d;
            out_q         <= out_d;
`ifdef PWM_OS_REPEAT_EN
            os_cnt_q      <= os_cnt_d;
`endif
        end
    end

    // Losing enable overrides every state; otherwise a dropped run finishes the current period.
    always_comb begin
        state_d = state_q;
        if (!cfg_pwm_enb) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (cfg_pwm_run) state_d = S_LOAD;
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    if (w_period_end) begin
                        if (w_os_finish)       state_d = S_DONE;
                        else if (!cfg_pwm_run) state_d = S_IDLE;
                    end else if (!cfg_pwm_run) begin
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_period_end) begin
                        if (w_os_finish)      state_d = S_DONE;
                        else if (cfg_pwm_run) state_d = S_RUN;
                        else                  state_d = S_IDLE;
                    end else if (cfg_pwm_run) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: if (!cfg_pwm_run) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d         = '0;
        act_period_d  = act_period_q;
        act_compare_d = act_compare_q;
        ld_pend_d     = ld_pend_q | cfg_ld_req;
        ovflow_d      = 1'b0;
        os_done_d     = 1'b0;
        out_d         = cfg_polarity;
`ifdef PWM_OS_REPEAT_EN
        os_cnt_d      = os_cnt_q;
`endif
        if (cfg_pwm_enb) begin
            if (state_q == S_LOAD) begin
                act_period_d  = cfg_period;
                act_compare_d = cfg_compare;
                ld_pend_d     = 1'b0;
`ifdef PWM_OS_REPEAT_EN
                os_cnt_d      = '0;
`endif
            end else if (w_counting) begin
                out_d = (cnt_q < act_compare_q) ^ cfg_polarity;
                if (w_period_end) begin
                    ovflow_d  = 1'b1;
                    os_done_d = w_os_finish;
`ifdef PWM_OS_REPEAT_EN
                    if (cfg_oneshot) os_cnt_d = os_cnt_q + OS_W'(1);
`endif
                    if ((ld_pend_q | cfg_ld_req) && !cfg_pwm_dupdate) begin
                        act_period_d  = cfg_period;
                        act_compare_d = cfg_compare;
                        ld_pend_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign pwm_out     = out_q;
    assign pwm_ovflow  = ovflow_q;
    assign pwm_os_done = os_done_q;
    assign ld_pend     = ld_pend_q;
    assign cnt_val     = cnt_q;
    assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pwm_chan_seq.sv
// Directed self-checking bench for pwm_chan_seq.
`default_nettype none

module tb_pwm_chan_seq;

`ifdef PWM_OS_REPEAT_EN
    localparam int OS_PERIODS = 3;
`else
    localparam int OS_PERIODS = 1;
`endif

    logic        mclk = 1'b0;
    logic        h_reset;
    logic        cfg_pwm_enb, cfg_pwm_run, cfg_pwm_dupdate, cfg_oneshot, cfg_polarity;
    logic [7:0]  cfg_os_rpt;
    logic [15:0] cfg_period, cfg_compare;
    logic        cfg_ld_req;
    logic        pwm_out, pwm_ovflow, pwm_os_done, ld_pend, busy;
    logic [15:0] cnt_val;

    int n_err = 0;
    int n_chk = 0;
    int k_done;

    pwm_chan_seq #(.CNT_W(16), .OS_W(8)) dut (
        .mclk(mclk), .h_reset(h_reset),
        .cfg_pwm_enb(cfg_pwm_enb), .cfg_pwm_run(cfg_pwm_run),
        .cfg_pwm_dupdate(cfg_pwm_dupdate), .cfg_oneshot(cfg_oneshot),
        .cfg_polarity(cfg_polarity), .cfg_os_rpt(cfg_os_rpt),
        .cfg_period(cfg_period), .cfg_compare(cfg_compare),
        .cfg_ld_req(cfg_ld_req), .pwm_out(pwm_out), .pwm_ovflow(pwm_ovflow),
        .pwm_os_done(pwm_os_done), .ld_pend(ld_pend), .cnt_val(cnt_val),
        .busy(busy)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the channel in RUN with cnt_val = 0 (LOAD cycle has just passed).
    task automatic start();
        cfg_pwm_enb = 1'b0;
        tick();
        cfg_pwm_enb = 1'b1;
        cfg_pwm_run = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        h_reset = 1'b1;
        cfg_pwm_enb = 0; cfg_pwm_run = 0; cfg_pwm_dupdate = 0; cfg_oneshot = 0;
        cfg_polarity = 0; cfg_os_rpt = 8'd2; cfg_period = 16'd9; cfg_compare = 16'd3;
        cfg_ld_req = 0;
        tick();
        tick();
        chk("rst_out", pwm_out, 0);
        chk("rst_cnt", cnt_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ldp", ld_pend, 0);
        chk("rst_ovf", pwm_ovflow, 0);
        chk("rst_osd", pwm_os_done, 0);
        h_reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Continuous: period 10, 3 high / 7 low.
        start();
        chk("c_cnt0", cnt_val, 0);
        chk("c_out0", pwm_out, 0);
        for (int k = 1; k <= 25; k++) begin
            tick();
            chk("c_cnt", cnt_val, 32'(k % 10));
            chk("c_out", pwm_out, 32'(((k - 1) % 10) < 3));
            chk("c_ovf", pwm_ovflow, 32'((k % 10) == 0));
            chk("c_osd", pwm_os_done, 0);
        end

        // One-shot: period 5.
        cfg_oneshot = 1; cfg_period = 16'd4; cfg_compare = 16'd2; cfg_os_rpt = 8'd2;
        start();
        k_done = 5 * OS_PERIODS;
        for (int k = 1; k <= 22; k++) begin
            tick();
            chk("os_ovf", pwm_ovflow, 32'((k % 5) == 0 && k <= k_done));
            chk("os_done", pwm_os_done, 32'(k == k_done));
            chk("os_busy", busy, 32'(k <= k_done + 1));
            if (k == k_done + 1) cfg_pwm_run = 1'b0;
        end
        cfg_oneshot = 0;

        // Shadow update held off by dupdate for two period ends.
        cfg_period = 16'd9; cfg_compare = 16'd3;
        start();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 4) cfg_ld_req = 1'b0;
            chk("sh_ldp", ld_pend, 32'(k >= 4 && k < 30));
            if (k == 14) chk("sh_out14", pwm_out, 0);
            if (k == 22) chk("sh_out22", pwm_out, 1);
            if (k == 24) chk("sh_out24", pwm_out, 0);
            if (k == 34) chk("sh_out34", pwm_out, 1);
            if (k == 38) chk("sh_out38", pwm_out, 1);
            if (k == 39) chk("sh_out39", pwm_out, 0);
            if (k == 3) begin
                cfg_compare = 16'd8; cfg_ld_req = 1'b1; cfg_pwm_dupdate = 1'b1;
            end
            if (k == 20) cfg_pwm_dupdate = 1'b0;
        end

        // Graceful stop with polarity 1.
        cfg_compare = 16'd3; cfg_polarity = 1'b1;
        start();
        tick(); tick();
        chk("st_cnt2", cnt_val, 2);
        cfg_pwm_run = 1'b0;
        for (int k = 3; k <= 12; k++) begin
            tick();
            if (k <= 9) begin
                chk("st_cnt", cnt_val, 32'(k));
                chk("st_busy", busy, 1);
                chk("st_ovf", pwm_ovflow, 0);
            end
        end
        // k=12 now; recheck the stop landing by state only
        chk("st_idle", busy, 0);
        chk("st_out", pwm_out, 1);

        // Repeat the stop to catch the ovflow pulse at its exact cycle.
        start();
        tick(); tick();
        cfg_pwm_run = 1'b0;
        for (int k = 3; k <= 11; k++) begin
            tick();
            if (k == 10) begin
                chk("st2_ovf", pwm_ovflow, 1);
                chk("st2_busy", busy, 0);
                chk("st2_cnt", cnt_val, 0);
                chk("st2_out10", pwm_out, 1);
            end
            if (k == 11) chk("st2_ovf11", pwm_ovflow, 0);
        end

        // Abort by dropping enable at cnt = 2.
        start();
        tick(); tick();
        chk("ab_cnt2", cnt_val, 2);
        cfg_pwm_enb = 1'b0;
        for (int k = 3; k <= 12; k++) begin
            tick();
            chk("ab_busy", busy, 0);
            chk("ab_cnt", cnt_val, 0);
            chk("ab_ovf", pwm_ovflow, 0);
        end
        chk("ab_out", pwm_out, 1);

        // Edge values with polarity 0.
        cfg_polarity = 1'b0; cfg_compare = 16'd0; cfg_period = 16'd9;
        start();
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("e_cmp0", pwm_out, 0);
        end
        cfg_compare = 16'd20;
        start();
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("e_cmp20", pwm_out, 1);
        end
        cfg_period = 16'd0; cfg_compare = 16'd0;
        start();
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("e_p0_ovf", pwm_ovflow, 1);
            chk("e_p0_cnt", cnt_val, 0);
        end

        // Asynchronous reset mid-run at cnt = 5, polarity 1.
        cfg_polarity = 1'b1; cfg_period = 16'd9; cfg_compare = 16'd9;
        start();
        for (int k = 1; k <= 5; k++) tick();
        chk("ar_cnt5", cnt_val, 5);
        #2 h_reset = 1'b1;
        #1;
        chk("ar_out", pwm_out, 0);
        chk("ar_cnt", cnt_val, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ovf", pwm_ovflow, 0);
        chk("ar_osd", pwm_os_done, 0);
        chk("ar_ldp", ld_pend, 0);
        cfg_pwm_run = 1'b0;
        tick();
        h_reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("ar_idle", busy, 0);
        end
        chk("ar_pol", pwm_out, 1);
        cfg_pwm_run = 1'b1;
        tick();
        chk("ar_restart", busy, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pwm_chan_seq.md
Name: pwm_chan_seq

Overview:
- Per-channel PWM time-base sequencer; one instance per channel, three instances in the PWM subsystem.
- Consumes cfg_pwm_enb / cfg_pwm_run / cfg_pwm_dupdate bits from the PWM global register block.
- Returns pwm_ovflow and pwm_os_done pulses to that block.
- Owns the period counter, shadow-to-active config loading, one-shot sequencing and waveform generation.

Parameters:
- CNT_W, 16, width of period/compare/counter.
- OS_W, 8, width of one-shot repeat count.

Ports:
- mclk  in  1  system clock; single clock domain.
- h_reset  in  1  reset, asynchronous, active-high.
- cfg_pwm_enb  in  1  channel enable.
- cfg_pwm_run  in  1  run request; cleared externally after pwm_os_done.
- cfg_pwm_dupdate  in  1  1 = block shadow-to-active loads.
- cfg_oneshot  in  1  1 = one-shot mode, 0 = continuous.
- cfg_polarity  in  1  inactive output level.
- cfg_os_rpt  in  OS_W  periods per one-shot, minus 1.
- cfg_period  in  CNT_W  staged period, minus 1.
- cfg_compare  in  CNT_W  staged high-time in clocks.
- cfg_ld_req  in  1  pulse; staged period/compare were written.
- pwm_out  out  1  waveform.
- pwm_ovflow  out  1  1-cycle pulse at every period end.
- pwm_os_done  out  1  1-cycle pulse at one-shot completion.
- ld_pend  out  1  shadow load pending.
- cnt_val  out  CNT_W  current counter.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset values (h_reset high, async): FSM = IDLE; cnt_val = 0; os_cnt = 0; act_period = 0; act_compare = 0; ld_pend = 0; pwm_ovflow = 0; pwm_os_done = 0; busy = 0; pwm_out = 0.
- pwm_out is registered. Reset mid-operation aborts immediately, with no pulses.
- States: IDLE, LOAD, RUN, STOP, DONE.
- IDLE:
  - pwm_out = cfg_polarity.
  - enb & run -> LOAD.
- LOAD (1 cycle):
  - act_period <= cfg_period; act_compare <= cfg_compare.
  - ld_pend <= 0; cnt <= 0; os_cnt <= 0.
  - -> RUN.
  - Loads unconditionally, ignoring dupdate.
- RUN:
  - cnt increments each cycle.
  - Period end is the cycle cnt == act_period. At period end:
    - cnt <= 0; pwm_ovflow pulses the next cycle.
    - If (ld_pend | cfg_ld_req) & !cfg_pwm_dupdate: load active regs, clear ld_pend.
    - If dupdate is 1: ld_pend is held.
  - Load latency: a write with ld_req takes effect from the period following the next period end.
  - ld_req in the same cycle as a period end is honoured at that boundary.
- Waveform:
  - Active while cnt < act_compare; pwm_out = active ^ cfg_polarity, registered (1-cycle latency).
  - act_compare = 0 -> never active.
  - act_compare > act_period -> always active.
  - act_period = 0 -> pwm_ovflow every cycle.
- One-shot (cfg_oneshot = 1):
  - os_cnt increments at each period end.
  - At the period end where os_cnt == cfg_os_rpt: pwm_os_done pulses (same cycle as that pwm_ovflow) and FSM -> DONE.
  - Total periods = cfg_os_rpt + 1.
  - os_cnt wraps never; it is reset in LOAD.
- cfg_pwm_run falls in RUN:
  - -> STOP. Counting continues to the current period end, then -> IDLE (ovflow still pulses).
  - Run re-asserted during STOP -> back to RUN, with no reload.
- cfg_pwm_enb falls in any state: -> IDLE next cycle, cnt = 0, no pulses; ld_pend retained.
- DONE:
  - pwm_out = cfg_polarity.
  - Waits for cfg_pwm_run = 0, then -> IDLE.
  - Prevents retrigger during the 1-cycle clear latency of the run bit.
- cfg_ld_req in any state sets ld_pend unless consumed the same cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro: PWM_OS_REPEAT_EN.
- Defined: behaviour as above, with cfg_os_rpt honoured.
- Undefined: cfg_os_rpt is ignored and no os_cnt register exists. One-shot = exactly one period; pwm_os_done fires at the first period end.

Test Plan:
1. Continuous mode:
   - Stimulus: polarity = 0, period = 9, compare = 3, enb = run = 1.
   - Required: pwm_out high 3 / low 7 clocks, repeating; pwm_ovflow every 10 clocks; cnt_val wraps 9 -> 0.
2. One-shot:
   - Stimulus: oneshot = 1, os_rpt = 2, period = 4; external run cleared 1 cycle after os_done.
   - Required: exactly 3 ovflow pulses; os_done coincident with the 3rd; FSM DONE then IDLE; no restart.
3. Shadow update:
   - Stimulus: mid-period write compare = 8, ld_req, with dupdate = 1 for 2 periods, then dupdate = 0.
   - Required: ld_pend = 1 for 2 periods; new compare active only after the first period end with dupdate = 0.
4. Graceful stop and abort:
   - Stimulus: drop run at cnt = 2 (period = 9).
   - Required: counting continues to 9, ovflow pulses, then IDLE with pwm_out = polarity.
   - Stimulus: drop enb at cnt = 2.
   - Required: IDLE next cycle, no ovflow.
5. Edge values:
   - compare = 0 -> pwm_out constant inactive.
   - compare = 20, period = 9 -> constant active.
   - period = 0 -> ovflow asserted every cycle.
6. Async reset:
   - Stimulus: assert h_reset mid-RUN at cnt = 5.
   - Required: all outputs 0 immediately; after release, FSM IDLE until the next enb & run.
